// File: rtl/regfile_port_arbiter.sv
// regfile_port_arbiter
//
// Shares the single read/write port of RegFile between a write-back
// requester and an operand-read requester. Writes are queued in a small
// FIFO write buffer. Reads take the port first. The buffer drains on cycles
// with no read request, or forcibly when it is full. A read that hits a
// buffered, uncommitted write is bypassed from the buffer, so every read
// returns the newest architectural value.
//
// Handshakes: a request transfers on a cycle where valid && ready are both 1.
// A requester holds valid and its payload stable until that transfer. The
// read response is a one-cycle pulse with no backpressure.
//
// Ports
//   clk, rst                 clock; synchronous active-high reset
//   wr_valid/ready/addr/data write-back request
//   rd_valid/ready/rs1/rs2/tag  operand-read request
//   rsp_valid/rs1v/rs2v/tag  read response, one cycle after issue
//   rf_rw/rd/rs1/rs2/din     RegFile port control (rw: 1=read, 0=write)
//   rf_rs1v/rf_rs2v          RegFile registered read data
module regfile_port_arbiter #(
  parameter int WB_DEPTH = 2,
  parameter int TAG_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [4:0]       wr_addr,
  input  logic [31:0]      wr_data,
  input  logic             rd_valid,
  output logic             rd_ready,
  input  logic [4:0]       rd_rs1,
  input  logic [4:0]       rd_rs2,
  input  logic [TAG_W-1:0] rd_tag,
  output logic             rsp_valid,
  output logic [31:0]      rsp_rs1v,
  output logic [31:0]      rsp_rs2v,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rf_rw,
  output logic [4:0]       rf_rd,
  output logic [4:0]       rf_rs1,
  output logic [4:0]       rf_rs2,
  output logic [31:0]      rf_din,
  input  logic [31:0]      rf_rs1v,
  input  logic [31:0]      rf_rs2v
);

  localparam int PW = $clog2(WB_DEPTH);
  localparam int CW = PW + 1;

  logic [4:0]       buf_addr [WB_DEPTH];
  logic [31:0]      buf_data [WB_DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [CW-1:0]    count;

  logic             full;
  logic             do_read;
  logic             do_drain;
  logic             push;

  logic             hit1;
  logic             hit2;
  logic [31:0]      byp1;
  logic [31:0]      byp2;
  logic [PW-1:0]    idx;

  logic             rsp_valid_q;
  logic             hit1_q;
  logic             hit2_q;
  logic [31:0]      byp1_q;
  logic [31:0]      byp2_q;
  logic [TAG_W-1:0] tag_q;

  // Port decision uses only the registered count, so a full buffer never
  // accepts a write in the same cycle it frees a slot.
  assign full     = (count == CW'(WB_DEPTH));
  assign wr_ready = !rst && !full;
  assign do_read  = !rst && !full && rd_valid;
  assign do_drain = !rst && (full || (!rd_valid && count != '0));
  assign rd_ready = do_read;
  assign push     = wr_valid && wr_ready;

  always_comb begin
    rf_rw  = 1'b1;
    rf_rd  = '0;
    rf_rs1 = '0;
    rf_rs2 = '0;
    rf_din = '0;
    if (do_drain) begin
      rf_rw  = 1'b0;
      rf_rd  = buf_addr[head];
      rf_din = buf_data[head];
    end else if (do_read) begin
      rf_rs1 = rd_rs1;
      rf_rs2 = rd_rs2;
    end
  end

  // Scan entries oldest to newest; a later match overwrites an earlier one,
  // so the newest matching write wins. Nothing is popped on a read cycle,
  // so every counted entry is a candidate.
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    byp1 = '0;
    byp2 = '0;
    idx  = '0;
    for (int k = 0; k < WB_DEPTH; k++) begin
      idx = head + PW'(k);
      if (CW'(k) < count) begin
        if (buf_addr[idx] == rd_rs1) begin
          hit1 = 1'b1;
          byp1 = buf_data[idx];
        end
        if (buf_addr[idx] == rd_rs2) begin
          hit2 = 1'b1;
          byp2 = buf_data[idx];
        end
      end
    end
  end

  // Buffer storage needs no reset: only entries below count are ever used.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_addr[tail] <= wr_addr;
      buf_data[tail] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      rsp_valid_q <= 1'b0;
      hit1_q      <= 1'b0;
      hit2_q      <= 1'b0;
      byp1_q      <= '0;
      byp2_q      <= '0;
      tag_q       <= '0;
    end else begin
      if (push)     tail <= tail + PW'(1);
      if (do_drain) head <= head + PW'(1);
      case ({push, do_drain})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      rsp_valid_q <= do_read;
      if (do_read) begin
        hit1_q <= hit1;
        hit2_q <= hit2;
        byp1_q <= byp1;
        byp2_q <= byp2;
        tag_q  <= rd_tag;
      end
    end
  end

  // RegFile data arrives registered in the response cycle, so the bypass
  // choice is a mux on the live rf_rs*v inputs.
  assign rsp_valid = rsp_valid_q && !rst;
  assign rsp_rs1v  = rsp_valid ? (hit1_q ? byp1_q : rf_rs1v) : '0;
  assign rsp_rs2v  = rsp_valid ? (hit2_q ? byp2_q : rf_rs2v) : '0;
  assign rsp_tag   = rsp_valid ? tag_q : '0;

endmodule

// File: tb/tb_regfile_port_arbiter.sv
module tb_regfile_port_arbiter;

  localparam int WB_DEPTH = 2;
  localparam int TAG_W    = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             wr_valid = 1'b0;
  logic             wr_ready;
  logic [4:0]       wr_addr = '0;
  logic [31:0]      wr_data = '0;
  logic             rd_valid = 1'b0;
  logic             rd_ready;
  logic [4:0]       rd_rs1 = '0;
  logic [4:0]       rd_rs2 = '0;
  logic [TAG_W-1:0] rd_tag = '0;
  logic             rsp_valid;
  logic [31:0]      rsp_rs1v;
  logic [31:0]      rsp_rs2v;
  logic [TAG_W-1:0] rsp_tag;
  logic             rf_rw;
  logic [4:0]       rf_rd;
  logic [4:0]       rf_rs1;
  logic [4:0]       rf_rs2;
  logic [31:0]      rf_din;
  logic [31:0]      rf_rs1v;
  logic [31:0]      rf_rs2v;

  int checks   = 0;
  int failures = 0;

  regfile_port_arbiter #(.WB_DEPTH(WB_DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_rs1(rd_rs1), .rd_rs2(rd_rs2),
    .rd_tag(rd_tag),
    .rsp_valid(rsp_valid), .rsp_rs1v(rsp_rs1v), .rsp_rs2v(rsp_rs2v), .rsp_tag(rsp_tag),
    .rf_rw(rf_rw), .rf_rd(rf_rd), .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_din(rf_din),
    .rf_rs1v(rf_rs1v), .rf_rs2v(rf_rs2v)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- RegFile stand-in ----------------
  logic [31:0] rf_mem [32];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf_mem[i] <= '0;
      rf_rs1v <= '0;
      rf_rs2v <= '0;
    end else begin
      if (!rf_rw) rf_mem[rf_rd] <= rf_din;
      rf_rs1v <= rf_mem[rf_rs1];
      rf_rs2v <= rf_mem[rf_rs2];
    end
  end

  // ---------------- reference model + scoreboard ----------------
  // arch[] is the architectural register state: every accepted write applied
  // in acceptance order. exp_q holds accepted-but-uncommitted {addr,data}.
  logic [31:0]      arch [32];
  logic [36:0]      exp_q [$];
  bit               rsp_pend = 1'b0;
  logic [31:0]      exp_rs1v, exp_rs2v;
  logic [TAG_W-1:0] exp_tag;

  initial for (int i = 0; i < 32; i++) arch[i] = '0;

  always @(negedge clk) begin
    int  mcount;
    bit  exp_drain, exp_read, exp_wacc;
    if (rst) begin
      checks++;
      if (rsp_valid !== 1'b0 || rsp_rs1v !== '0 || rsp_rs2v !== '0 || rsp_tag !== '0 ||
          wr_ready !== 1'b0 || rd_ready !== 1'b0 || rf_rw !== 1'b1 || rf_rd !== '0 ||
          rf_rs1 !== '0 || rf_rs2 !== '0 || rf_din !== '0) begin
        failures++;
        $display("FAIL reset_outputs: rsp_valid=%b wr_ready=%b rd_ready=%b rf_rw=%b rf_rd=%0d rf_din=%h required all idle",
                 rsp_valid, wr_ready, rd_ready, rf_rw, rf_rd, rf_din);
      end
      for (int i = 0; i < 32; i++) arch[i] = '0;
      exp_q.delete();
      rsp_pend = 1'b0;
    end else begin
      checks++;
      if (rsp_valid !== rsp_pend) begin
        failures++;
        $display("FAIL rsp_valid: got %b required %b", rsp_valid, rsp_pend);
      end
      checks++;
      if (rsp_pend) begin
        if (rsp_rs1v !== exp_rs1v || rsp_rs2v !== exp_rs2v || rsp_tag !== exp_tag) begin
          failures++;
          $display("FAIL rsp_data: got rs1v=%h rs2v=%h tag=%h required rs1v=%h rs2v=%h tag=%h",
                   rsp_rs1v, rsp_rs2v, rsp_tag, exp_rs1v, exp_rs2v, exp_tag);
        end
      end else if (rsp_rs1v !== '0 || rsp_rs2v !== '0 || rsp_tag !== '0) begin
        failures++;
        $display("FAIL rsp_idle_zero: got rs1v=%h rs2v=%h tag=%h required 0", rsp_rs1v, rsp_rs2v, rsp_tag);
      end

      mcount    = exp_q.size();
      exp_drain = (mcount == WB_DEPTH) || (!rd_valid && mcount > 0);
      exp_read  = (mcount < WB_DEPTH) && rd_valid;
      exp_wacc  = (mcount < WB_DEPTH) && wr_valid;

      checks++;
      if (wr_ready !== (mcount < WB_DEPTH) || rd_ready !== exp_read) begin
        failures++;
        $display("FAIL ready: got wr_ready=%b rd_ready=%b required %b %b",
                 wr_ready, rd_ready, (mcount < WB_DEPTH), exp_read);
      end
      checks++;
      if (rf_rw !== !exp_drain) begin
        failures++;
        $display("FAIL rf_rw: got %b required %b (buffered=%0d)", rf_rw, !exp_drain, mcount);
      end

      if (exp_drain) begin
        checks++;
        if ({rf_rd, rf_din} !== exp_q[0]) begin
          failures++;
          $display("FAIL commit_order: got rd=%0d din=%h required rd=%0d din=%h",
                   rf_rd, rf_din, exp_q[0][36:32], exp_q[0][31:0]);
        end
        void'(exp_q.pop_front());
      end else begin
        checks++;
        if (exp_read ? (rf_rs1 !== rd_rs1 || rf_rs2 !== rd_rs2) : (rf_rs1 !== '0 || rf_rs2 !== '0)) begin
          failures++;
          $display("FAIL rf_read_addr: got rs1=%0d rs2=%0d read=%b", rf_rs1, rf_rs2, exp_read);
        end
      end

      // A read issued this cycle sees the state before this cycle's write.
      rsp_pend = exp_read;
      if (exp_read) begin
        exp_rs1v = arch[rd_rs1];
        exp_rs2v = arch[rd_rs2];
        exp_tag  = rd_tag;
      end
      if (exp_wacc) begin
        arch[wr_addr] = wr_data;
        exp_q.push_back({wr_addr, wr_data});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    wr_valid = 1'b0;
    rd_valid = 1'b0;
  endtask

  task automatic drive_wr(input logic [4:0] a, input logic [31:0] d);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
  endtask

  task automatic drive_rd(input logic [4:0] r1, input logic [4:0] r2, input logic [TAG_W-1:0] t);
    rd_valid = 1'b1;
    rd_rs1   = r1;
    rd_rs2   = r2;
    rd_tag   = t;
  endtask

  task automatic wait_empty();
    int n = 0;
    drive_idle();
    while ((exp_q.size() != 0 || rsp_pend) && n < 20) begin
      tick();
      @(negedge clk);
      n++;
    end
    tick();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout: %0d writes still buffered after %0d cycles", exp_q.size(), n);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    drive_idle();
    repeat (3) tick();
    @(negedge clk);
    checks++;
    if (wr_ready !== 1'b0 || rf_rw !== 1'b1) begin
      failures++;
      $display("FAIL test_reset_hold: wr_ready=%b rf_rw=%b required 0 1", wr_ready, rf_rw);
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (wr_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL test_reset_release: wr_ready=%b rsp_valid=%b required 1 0", wr_ready, rsp_valid);
    end
    tick();
  endtask

  task automatic test_write_drain();
    drive_wr(5'd5, 32'hDEADBEEF);
    tick();
    drive_idle();
    @(negedge clk);
    checks++;
    if (rf_rw !== 1'b0 || rf_rd !== 5'd5 || rf_din !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL test_write_drain: rf_rw=%b rf_rd=%0d rf_din=%h required 0 5 deadbeef", rf_rw, rf_rd, rf_din);
    end
    tick();
    drive_rd(5'd5, 5'd0, 4'd3);
    tick();
    drive_idle();
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rs1v !== 32'hDEADBEEF || rsp_rs2v !== '0 || rsp_tag !== 4'd3) begin
      failures++;
      $display("FAIL test_read_committed: valid=%b rs1v=%h rs2v=%h tag=%h required 1 deadbeef 0 3",
               rsp_valid, rsp_rs1v, rsp_rs2v, rsp_tag);
    end
    tick();
  endtask

  task automatic test_bypass();
    drive_wr(5'd7, 32'h11);
    tick();
    wr_valid = 1'b0;
    drive_rd(5'd7, 5'd7, 4'd9);
    tick();
    drive_idle();
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rs1v !== 32'h11 || rsp_rs2v !== 32'h11 || rsp_tag !== 4'd9) begin
      failures++;
      $display("FAIL test_bypass: valid=%b rs1v=%h rs2v=%h tag=%h required 1 11 11 9",
               rsp_valid, rsp_rs1v, rsp_rs2v, rsp_tag);
    end
    wait_empty();
  endtask

  task automatic test_newest();
    drive_wr(5'd3, 32'd1);
    drive_rd(5'd0, 5'd0, 4'd1);
    tick();
    drive_wr(5'd3, 32'd2);
    drive_rd(5'd0, 5'd0, 4'd2);
    tick();
    wr_valid = 1'b0;
    drive_rd(5'd3, 5'd3, 4'd4);
    @(negedge clk);
    checks++;
    if (rd_ready !== 1'b0 || rf_rw !== 1'b0) begin
      failures++;
      $display("FAIL test_full_drain_stall: rd_ready=%b rf_rw=%b required 0 0", rd_ready, rf_rw);
    end
    tick();
    tick();
    drive_idle();
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rs1v !== 32'd2 || rsp_tag !== 4'd4) begin
      failures++;
      $display("FAIL test_newest: valid=%b rs1v=%h tag=%h required 1 2 4", rsp_valid, rsp_rs1v, rsp_tag);
    end
    wait_empty();
    drive_rd(5'd3, 5'd0, 4'd5);
    tick();
    drive_idle();
    @(negedge clk);
    checks++;
    if (rsp_rs1v !== 32'd2) begin
      failures++;
      $display("FAIL test_newest_committed: rs1v=%h required 2", rsp_rs1v);
    end
    tick();
  endtask

  task automatic test_full_stall();
    int widx = 0;
    int stalls = 0;
    bit saw_full = 1'b0;
    logic [31:0] wd [3];
    wd[0] = 32'hA0; wd[1] = 32'hA1; wd[2] = 32'hA2;
    drive_rd(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), TAG_W'($urandom));
    for (int c = 0; c < 10; c++) begin
      if (widx < 3) drive_wr(5'(20 + widx), wd[widx]);
      else          wr_valid = 1'b0;
      @(negedge clk);
      if (wr_ready === 1'b0) saw_full = 1'b1;
      if (rd_ready === 1'b0) stalls++;
      if (wr_valid && wr_ready) widx++;
      if (rd_ready) begin
        tick();
        drive_rd(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), TAG_W'($urandom));
      end else begin
        tick();
      end
    end
    checks++;
    if (!saw_full || stalls != 2 || widx != 3) begin
      failures++;
      $display("FAIL test_full_stall: saw_full=%b stalls=%0d writes=%0d required 1 2 3", saw_full, stalls, widx);
    end
    wait_empty();
  endtask

  task automatic test_same_cycle();
    drive_wr(5'd9, 32'h55);
    drive_rd(5'd9, 5'd9, 4'd6);
    tick();
    wr_valid = 1'b0;
    drive_rd(5'd9, 5'd0, 4'd7);
    @(negedge clk);
    checks++;
    if (rsp_rs1v !== 32'h0 || rsp_rs2v !== 32'h0 || rsp_tag !== 4'd6) begin
      failures++;
      $display("FAIL test_same_cycle_old: rs1v=%h rs2v=%h tag=%h required 0 0 6", rsp_rs1v, rsp_rs2v, rsp_tag);
    end
    tick();
    drive_idle();
    @(negedge clk);
    checks++;
    if (rsp_rs1v !== 32'h55 || rsp_tag !== 4'd7) begin
      failures++;
      $display("FAIL test_same_cycle_new: rs1v=%h tag=%h required 55 7", rsp_rs1v, rsp_tag);
    end
    wait_empty();
  endtask

  task automatic test_reset_mid();
    drive_wr(5'd12, 32'hAA);
    drive_rd(5'd0, 5'd0, 4'd1);
    tick();
    drive_wr(5'd13, 32'hBB);
    drive_rd(5'd1, 5'd2, 4'd2);
    tick();
    rst = 1'b1;
    drive_idle();
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL test_reset_mid_rsp: rsp_valid=%b required 0", rsp_valid);
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (wr_ready !== 1'b1) begin
      failures++;
      $display("FAIL test_reset_mid_ready: wr_ready=%b required 1", wr_ready);
    end
    tick();
    drive_rd(5'd12, 5'd13, 4'd8);
    tick();
    drive_idle();
    @(negedge clk);
    checks++;
    if (rsp_rs1v !== 32'h0 || rsp_rs2v !== 32'h0) begin
      failures++;
      $display("FAIL test_reset_mid_lost: rs1v=%h rs2v=%h required 0 0", rsp_rs1v, rsp_rs2v);
    end
    tick();
  endtask

  task automatic test_random();
    bit wacc, racc;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      wacc = wr_valid && wr_ready;
      racc = rd_valid && rd_ready;
      tick();
      if (!wr_valid || wacc) begin
        wr_valid = ($urandom_range(0, 99) < 45);
        wr_addr  = 5'($urandom_range(0, 7));
        wr_data  = $urandom;
      end
      if (!rd_valid || racc) begin
        rd_valid = ($urandom_range(0, 99) < 60);
        rd_rs1   = 5'($urandom_range(0, 7));
        rd_rs2   = 5'($urandom_range(0, 7));
        rd_tag   = TAG_W'($urandom);
      end
    end
    wait_empty();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_write_drain();
    test_bypass();
    test_newest();
    test_full_stall();
    test_same_cycle();
    test_reset_mid();
    test_random();
    test_reset();
    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
